pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning max MEM_WAIT cycles before a timeout error (range 1..255).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports id_rs1, id_rs2  input  5 each  source register indices of the instruction in ID.
REQ-005 SHALL have ports ex_rd  input  5, ex_memread  input  1  destination and load flag of the instruction in EX.
REQ-006 SHALL have port ex_branch_taken  input  1  resolved taken branch/jump in EX.
REQ-007 SHALL have ports mem_access  input  1, dmem_ready  input  1  load/store present in MEM and data-memory completion.
REQ-008 SHALL have ports pc_en, if_id_en, id_ex_en, ex_mem_en  output  1 each  stage-register enables.
REQ-009 SHALL have ports if_id_flush, id_ex_flush  output  1 each  bubble-insert controls.
REQ-010 SHALL have port wb_bubble  output  1  forces the MEM/WB capture to regwrite=0, memtoreg=0.
REQ-011 SHALL have port dmem_req  output  1  data-memory request strobe.
REQ-012 SHALL have ports state  output  2 (RUN=0, MEM_WAIT=1, ERR=2), timeout_err  output  1 (sticky), stall_cnt  output  16.

Function
REQ-013 SHALL implement a 3-state FSM: RUN, MEM_WAIT, ERR; state and counters registered, control outputs combinational from state and inputs.
REQ-014 SHALL define mem_stall = (state==RUN) & mem_access & ~dmem_ready.
REQ-015 SHALL define load_use = ex_memread & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-016 SHALL, in RUN with no event, drive all four enables=1, flushes=0, wb_bubble=0, dmem_req=mem_access.
REQ-017 SHALL, on mem_stall, drive all enables=0, flushes=0, wb_bubble=1, dmem_req=1, and transition to MEM_WAIT with wait counter=1.
REQ-018 SHALL, in RUN without mem_stall and with ex_branch_taken, drive if_id_flush=1, id_ex_flush=1, all enables=1 (branch overrides load_use).
REQ-019 SHALL, in RUN without mem_stall or ex_branch_taken but with load_use, drive pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en=1, ex_mem_en=1 for exactly that cycle.
REQ-020 SHALL give priority mem_stall > ex_branch_taken > load_use; lower-priority events are re-evaluated after release because frozen stages hold their inputs.
REQ-021 SHALL, in MEM_WAIT with dmem_ready=0, hold all enables=0, wb_bubble=1, dmem_req=1, increment the wait counter.
REQ-022 SHALL, in MEM_WAIT with dmem_ready=1, drive RUN-style outputs per REQ-016/018/019 with dmem_req=1 that cycle, and return to RUN.
REQ-023 SHALL, when the wait counter equals MEM_TIMEOUT and dmem_ready=0 in MEM_WAIT, enter ERR next cycle and set timeout_err=1.
REQ-024 SHALL, in ERR, drive all enables=0, flushes=0, wb_bubble=1, dmem_req=0, and remain until rst.
REQ-025 SHALL increment stall_cnt each cycle pc_en==0 outside reset, saturating at 16'hFFFF.
REQ-026 SHALL treat ex_rd==0 as never hazardous regardless of ex_memread.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set state=RUN, wait counter=0, timeout_err=0, stall_cnt=0, overriding any event including mid-MEM_WAIT and ERR.
REQ-028 SHALL, while rst=1, drive all enables=0, flushes=0, wb_bubble=1, dmem_req=0; stall_cnt does not count these cycles.

Verification
REQ-029 SHALL test load-use: ex_memread=1, ex_rd=5, id_rs2=5 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1.
REQ-030 SHALL test x0 case: ex_memread=1, ex_rd=0, id_rs1=0 -> no stall, all enables=1.
REQ-031 SHALL test mem wait: mem_access=1, dmem_ready low 3 cycles then high -> MEM_WAIT 3 cycles, wb_bubble=1 those cycles, RUN after, stall_cnt=3.
REQ-032 SHALL test simultaneity: mem_stall with ex_branch_taken=1 -> freeze, no flush; flushes asserted on the ready cycle.
REQ-033 SHALL test timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> ERR after 4 wait cycles, timeout_err=1, dmem_req=0 until rst.
REQ-034 SHALL test reset mid-MEM_WAIT: rst=1 at wait count 2 -> state=RUN, stall_cnt=0, timeout_err=0 next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush and data-memory
// wait handling with a timeout trap. Control outputs are combinational from state and inputs.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memread,
    input  logic        ex_branch_taken,
    input  logic        mem_access,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        wb_bubble,
    output logic        dmem_req,
    output logic [1:0]  state,
    output logic        timeout_err,
    output logic [15:0] stall_cnt
);

    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned STALL_W = 16;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                timeout_err_q, timeout_err_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic mem_stall;
    logic load_use;

    // Hazard detection; x0 is never a real destination.
    always_comb begin
        mem_stall = (state_q == ST_RUN) && mem_access && !dmem_ready;
        load_use  = ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    end

    // Run-style controls shared by RUN and the MEM_WAIT release cycle.
    logic run_pc_en;
    logic run_if_id_en;
    logic run_if_id_flush;
    logic run_id_ex_flush;

    always_comb begin
        run_pc_en       = 1'b1;
        run_if_id_en    = 1'b1;
        run_if_id_flush = 1'b0;
        run_id_ex_flush = 1'b0;
        if (ex_branch_taken) begin
            run_if_id_flush = 1'b1;
            run_id_ex_flush = 1'b1;
        end else if (load_use) begin
            run_pc_en       = 1'b0;
            run_if_id_en    = 1'b0;
            run_id_ex_flush = 1'b1;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        timeout_err_d = timeout_err_q;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        wb_bubble     = 1'b1;
        dmem_req      = 1'b0;

        if (!rst) begin
            unique case (state_q)
                ST_RUN: begin
                    if (mem_stall) begin
                        dmem_req = 1'b1;
                        state_d  = ST_MEM_WAIT;
                        wait_d   = WAIT_W'(1);
                    end else begin
                        pc_en       = run_pc_en;
                        if_id_en    = run_if_id_en;
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        if_id_flush = run_if_id_flush;
                        id_ex_flush = run_id_ex_flush;
                        wb_bubble   = 1'b0;
                        dmem_req    = mem_access;
                    end
                end
                ST_MEM_WAIT: begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        pc_en       = run_pc_en;
                        if_id_en    = run_if_id_en;
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        if_id_flush = run_if_id_flush;
                        id_ex_flush = run_id_ex_flush;
                        wb_bubble   = 1'b0;
                        state_d     = ST_RUN;
                        wait_d      = '0;
                    end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d       = ST_ERR;
                        timeout_err_d = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                end
                default: begin
                    state_d = ST_ERR;
                end
            endcase
        end
    end

    // Stall counter saturates rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != {STALL_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_q        <= '0;
            timeout_err_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            timeout_err_q <= timeout_err_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign state       = state_q;
    assign timeout_err = timeout_err_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed check of pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_memread, ex_branch_taken, mem_access, dmem_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic        if_id_flush, id_ex_flush, wb_bubble, dmem_req;
    logic [1:0]  state;
    logic        timeout_err;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0=run, 1=waiting on memory, 2=error trap.
    int m_mode  = 0;
    int m_wait  = 0;
    int m_err   = 0;
    int m_stall = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .wb_bubble(wb_bubble), .dmem_req(dmem_req),
        .state(state), .timeout_err(timeout_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {pc,if_id,id_ex,ex_mem enables, if_id/id_ex flush, wb_bubble, dmem_req}.
    function automatic logic [7:0] model_ctrl();
        logic hazard;
        logic [7:0] v;
        hazard = ex_memread && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
        if (rst || m_mode == 2) return 8'b0000_0010;
        if (!dmem_ready && (m_mode == 1 || mem_access)) return 8'b0000_0011;
        v = {4'b1111, 2'b00, 1'b0, (m_mode == 1) ? 1'b1 : mem_access};
        if (ex_branch_taken) v[3:2] = 2'b11;
        else if (hazard) begin
            v[7:6] = 2'b00;
            v[2]   = 1'b1;
        end
        return v;
    endfunction

    // Compare this cycle's outputs, then advance model and DUT by one clock.
    task automatic step();
        logic [7:0] exp;
        #2;
        exp = model_ctrl();
        check("ctrl", {24'd0, pc_en, if_id_en, id_ex_en, ex_mem_en,
                       if_id_flush, id_ex_flush, wb_bubble, dmem_req}, {24'd0, exp});
        check("state", 32'(state), 32'(m_mode));
        check("timeout_err", 32'(timeout_err), 32'(m_err));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        if (rst) begin
            m_mode = 0; m_wait = 0; m_err = 0; m_stall = 0;
        end else begin
            if (!exp[7] && m_stall < 65535) m_stall++;
            if (m_mode == 0) begin
                if (mem_access && !dmem_ready) begin m_mode = 1; m_wait = 1; end
            end else if (m_mode == 1) begin
                if (dmem_ready) begin m_mode = 0; m_wait = 0; end
                else if (m_wait == TMO) begin m_mode = 2; m_err = 1; end
                else m_wait++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd1; id_rs2 = 5'd2; ex_rd = 5'd3; ex_memread = 1'b0;
        ex_branch_taken = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1; rst = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset_timeout", 32'(timeout_err), 32'd0);

        // Load-use on rs2.
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
        #1;
        check("lu_pc_en", 32'(pc_en), 32'd0);
        check("lu_if_id_en", 32'(if_id_en), 32'd0);
        check("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
        step();
        idle_inputs();
        step();
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        // x0 destination never stalls.
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        #1;
        check("x0_pc_en", 32'(pc_en), 32'd1);
        check("x0_id_ex_flush", 32'(id_ex_flush), 32'd0);
        step();

        // Memory wait: ready low three cycles.
        do_reset();
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mw_wb_bubble", 32'(wb_bubble), 32'd1);
            step();
        end
        check("mw_state_wait", 32'(state), 32'd1);
        dmem_ready = 1'b1;
        #1;
        check("mw_release_pc_en", 32'(pc_en), 32'd1);
        step();
        mem_access = 1'b0;
        check("mw_state_run", 32'(state), 32'd0);
        check("mw_stall_cnt", 32'(stall_cnt), 32'd3);

        // Memory stall wins over branch; flush lands on the ready cycle.
        do_reset();
        mem_access = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
        #1;
        check("sim_freeze_pc_en", 32'(pc_en), 32'd0);
        check("sim_no_flush", 32'({if_id_flush, id_ex_flush}), 32'd0);
        step();
        step();
        dmem_ready = 1'b1;
        #1;
        check("sim_release_flush", 32'({if_id_flush, id_ex_flush}), 32'd3);
        check("sim_release_req", 32'(dmem_req), 32'd1);
        step();
        idle_inputs();
        step();

        // Timeout into the error trap.
        do_reset();
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("to_state_err", 32'(state), 32'd2);
        check("to_timeout_err", 32'(timeout_err), 32'd1);
        check("to_dmem_req", 32'(dmem_req), 32'd0);
        dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("to_still_err", 32'(state), 32'd2);

        // Reset during the wait at count 2.
        do_reset();
        mem_access = 1'b1; dmem_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rmw_state", 32'(state), 32'd0);
        check("rmw_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rmw_timeout", 32'(timeout_err), 32'd0);

        // Random traffic with small register indices to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            ex_memread      = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_access      = ($urandom_range(0, 2) == 0);
            dmem_ready      = 1'($urandom_range(0, 1));
            rst             = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
